// File: rtl/parity_pkg.sv
`default_nettype none
// ============================================================================
// parity_pkg : shared types and sizing helpers for the parity frame checker
// Rev 1.0
// ============================================================================
package parity_pkg;

  // Storage width of the error count inside the result record.
  // It bounds the supported FRAME_LEN to 2**RES_CNT_W - 1.
  localparam int unsigned RES_CNT_W = 8;

  typedef enum logic [0:0] {
    S_ACCUM = 1'b0,
    S_HOLD  = 1'b1
  } state_t;

  typedef struct packed {
    logic                 frame_par;
    logic [RES_CNT_W-1:0] err_cnt;
    logic                 err;
  } result_t;

  function automatic int cw_of(input int frame_len);
    return $clog2(frame_len + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/parity_word.sv
`default_nettype none
// ============================================================================
// parity_word : XOR-reduction word parity with optional odd-sense inversion
// Rev 1.0
// ============================================================================
module parity_word #(
  parameter int WIDTH = 4,
  parameter int ODD   = 0
) (
  input  logic [WIDTH-1:0] data,
  output logic             wp
);

  logic [WIDTH-1:0] chain;

  assign chain[0] = data[0];

  // Gate-level chain keeps the structure identical to the upstream stage.
  for (genvar i = 1; i < WIDTH; i++) begin : g_xor
    xor u_xor (chain[i], chain[i-1], data[i]);
  end

  assign wp = chain[WIDTH-1] ^ (ODD != 0);

endmodule
`default_nettype wire

// File: rtl/parity_frame_checker.sv
`default_nettype none
// ============================================================================
// parity_frame_checker : per-frame parity/mismatch accumulator, valid/ready I/O
// Rev 1.0
// ============================================================================
module parity_frame_checker
  import parity_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int FRAME_LEN = 4,
  parameter int ODD       = 0,
  localparam int CW       = cw_of(FRAME_LEN)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          abort,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic          in_par,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_frame_par,
  output logic [CW-1:0] out_err_cnt,
  output logic          out_err
);

  localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic [CW-1:0] acc_err_q, acc_err_d;
  logic          acc_par_q, acc_par_d;
  result_t       res_q, res_d;

  logic          wp;
  logic          mismatch;
  logic          accept;
  logic          drain;
  logic [CW-1:0] err_sum;

  parity_word #(
    .WIDTH (WIDTH),
    .ODD   (ODD)
  ) u_parity_word (
    .data (in_data),
    .wp   (wp)
  );

  assign out_valid = (state_q == S_HOLD);
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign drain     = out_valid && out_ready;
  assign mismatch  = (wp != in_par);
  assign err_sum   = acc_err_q + CW'(mismatch);

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    acc_par_d = acc_par_q;
    acc_err_d = acc_err_q;
    res_d     = res_q;

    if (drain) begin
      state_d = S_ACCUM;
    end

    // Abort wins over an accepted word: the word is consumed but not counted.
    if (abort) begin
      wcnt_d    = '0;
      acc_par_d = 1'b0;
      acc_err_d = '0;
    end else if (accept) begin
      if (wcnt_q == LAST) begin
        res_d.frame_par = acc_par_q ^ wp;
        res_d.err_cnt   = RES_CNT_W'(err_sum);
        res_d.err       = (err_sum != '0);
        state_d         = S_HOLD;
        wcnt_d          = '0;
        acc_par_d       = 1'b0;
        acc_err_d       = '0;
      end else begin
        wcnt_d    = wcnt_q + 1'b1;
        acc_par_d = acc_par_q ^ wp;
        acc_err_d = err_sum;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_ACCUM;
      wcnt_q    <= '0;
      acc_par_q <= 1'b0;
      acc_err_q <= '0;
      res_q     <= '0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      acc_par_q <= acc_par_d;
      acc_err_q <= acc_err_d;
      res_q     <= res_d;
    end
  end

  assign out_frame_par = res_q.frame_par;
  assign out_err_cnt   = res_q.err_cnt[CW-1:0];
  assign out_err       = res_q.err;

  if (CW < RES_CNT_W) begin : g_cnt_hi
    logic unused_cnt_hi;
    assign unused_cnt_hi = ^res_q.err_cnt[RES_CNT_W-1:CW];
  end

endmodule
`default_nettype wire

// File: tb/tb_parity_frame_checker.sv
`default_nettype none
// ============================================================================
// tb_parity_frame_checker : directed stimulus, queue-based frame model
// Rev 1.0
// ============================================================================
module tb_parity_frame_checker;

  localparam int WIDTH     = 4;
  localparam int FRAME_LEN = 4;
  localparam bit ODD       = 1'b0;
  localparam int CW        = $clog2(FRAME_LEN + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          abort;
  logic          in_valid;
  logic          in_ready;
  logic [WIDTH-1:0] in_data;
  logic          in_par;
  logic          out_valid;
  logic          out_ready;
  logic          out_frame_par;
  logic [CW-1:0] out_err_cnt;
  logic          out_err;

  int total = 0;
  int bad   = 0;

  parity_frame_checker #(
    .WIDTH     (WIDTH),
    .FRAME_LEN (FRAME_LEN),
    .ODD       (ODD)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .abort         (abort),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .in_par        (in_par),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_frame_par (out_frame_par),
    .out_err_cnt   (out_err_cnt),
    .out_err       (out_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Frame model: collects word parities/mismatches of the current frame.
  bit m_valid, m_par, m_err;
  int m_cnt;
  bit q_wp[$];
  bit q_mis[$];
  bit m_rdy, m_wp;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid = 0; m_par = 0; m_cnt = 0; m_err = 0;
      q_wp.delete(); q_mis.delete();
    end else begin
      m_rdy = !m_valid || out_ready;
      if (m_valid && out_ready) m_valid = 0;
      if (abort) begin
        q_wp.delete(); q_mis.delete();
      end else if (in_valid && m_rdy) begin
        m_wp = bit'($countones(in_data) % 2) ^ ODD;
        q_wp.push_back(m_wp);
        q_mis.push_back(m_wp != in_par);
        if (q_wp.size() == FRAME_LEN) begin
          m_par = 0; m_cnt = 0;
          foreach (q_wp[k]) m_par ^= q_wp[k];
          foreach (q_mis[k]) m_cnt += int'(q_mis[k]);
          m_err   = (m_cnt != 0);
          m_valid = 1;
          q_wp.delete(); q_mis.delete();
        end
      end
    end
  end

  always @(negedge clk) begin
    check("in_ready", int'(in_ready), int'(!m_valid || out_ready));
    check("out_valid", int'(out_valid), int'(m_valid));
    if (m_valid) begin
      check("out_frame_par", int'(out_frame_par), int'(m_par));
      check("out_err_cnt", int'(out_err_cnt), m_cnt);
      check("out_err", int'(out_err), int'(m_err));
    end
  end

  task automatic cyc(input bit v, input logic [3:0] d, input bit p,
                     input bit r, input bit a);
    in_valid  = v;
    in_data   = d;
    in_par    = p;
    out_ready = r;
    abort     = a;
    @(posedge clk);
    #2;
  endtask

  task automatic expect_result(input string tag, input int par, input int cnt);
    check({tag, "_valid"}, int'(out_valid), 1);
    check({tag, "_par"}, int'(out_frame_par), par);
    check({tag, "_cnt"}, int'(out_err_cnt), cnt);
    check({tag, "_err"}, int'(out_err), int'(cnt != 0));
  endtask

  task automatic clean_frame(input bit r);
    cyc(1, 4'b0001, 1, r, 0);
    cyc(1, 4'b0011, 0, r, 0);
    cyc(1, 4'b0111, 1, r, 0);
    cyc(1, 4'b1111, 0, r, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; abort = 0; in_valid = 0; in_data = '0; in_par = 0; out_ready = 1;
    @(posedge clk); #2;
    @(posedge clk); #2;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_err_cnt", int'(out_err_cnt), 0);
    rst_n = 1;
    cyc(0, 4'b0000, 0, 1, 0);

    // Clean frame: result visible one cycle after the last word, for one cycle.
    clean_frame(1);
    expect_result("clean", 0, 0);
    check("model_clean_cnt", m_cnt, 0);
    cyc(0, 4'b0000, 0, 1, 0);
    check("clean_pulse_end", int'(out_valid), 0);

    // Second word tag flipped.
    cyc(1, 4'b0001, 1, 1, 0);
    cyc(1, 4'b0011, 1, 1, 0);
    cyc(1, 4'b0111, 1, 1, 0);
    cyc(1, 4'b1111, 0, 1, 0);
    expect_result("badtag", 0, 1);
    check("model_badtag_cnt", m_cnt, 1);
    cyc(0, 4'b0000, 0, 1, 0);

    // Backpressure on a frame with parity 1 and one mismatch.
    cyc(1, 4'b0001, 1, 0, 0);
    cyc(1, 4'b0000, 1, 0, 0);
    cyc(1, 4'b0000, 0, 0, 0);
    cyc(1, 4'b0000, 0, 0, 0);
    expect_result("bp_load", 1, 1);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 4'b0001, 1, 0, 0);
      check("bp_in_ready", int'(in_ready), 0);
      expect_result("bp_hold", 1, 1);
    end
    cyc(1, 4'b0001, 1, 1, 0);
    check("bp_drained", int'(out_valid), 0);
    cyc(1, 4'b0011, 0, 1, 0);
    cyc(1, 4'b0111, 1, 1, 0);
    check("bp_not_yet", int'(out_valid), 0);
    cyc(1, 4'b1111, 0, 1, 0);
    expect_result("bp_next", 0, 0);
    cyc(0, 4'b0000, 0, 1, 0);

    // Abort after two mismatched words; aborted-cycle word is discarded.
    cyc(1, 4'b0001, 0, 1, 0);
    cyc(1, 4'b0011, 1, 1, 0);
    cyc(1, 4'b0001, 0, 1, 1);
    cyc(1, 4'b0001, 1, 1, 0);
    cyc(1, 4'b0011, 0, 1, 0);
    cyc(1, 4'b0111, 1, 1, 0);
    check("abort_no_early", int'(out_valid), 0);
    cyc(1, 4'b1111, 0, 1, 0);
    expect_result("abort", 0, 0);
    cyc(0, 4'b0000, 0, 1, 0);

    // Reset mid-frame after three mismatched words.
    cyc(1, 4'b0001, 0, 1, 0);
    cyc(1, 4'b0011, 1, 1, 0);
    cyc(1, 4'b0111, 0, 1, 0);
    rst_n = 0;
    #1;
    check("midrst_in_ready", int'(in_ready), 1);
    cyc(0, 4'b0000, 0, 1, 0);
    rst_n = 1;
    cyc(0, 4'b0000, 0, 1, 0);
    cyc(1, 4'b0001, 1, 1, 0);
    cyc(1, 4'b0011, 0, 1, 0);
    cyc(1, 4'b0111, 1, 1, 0);
    check("midrst_no_spurious", int'(out_valid), 0);
    cyc(1, 4'b1111, 0, 1, 0);
    expect_result("midrst", 0, 0);
    cyc(0, 4'b0000, 0, 1, 0);
    cyc(0, 4'b0000, 0, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/parity_frame_checker.md
# parity_frame_checker

Streaming parity checker that sits directly downstream of the combinational XOR-reduction parity stage. It accepts data words, each tagged with a transmitted parity bit, over a valid/ready handshake. For every accepted word it recomputes the XOR reduction of the data and compares it against the tag. Over a frame of FRAME_LEN words it accumulates the frame parity and a count of bad words, then presents one result record per frame on a valid/ready output.

## Interface
- WIDTH, 4: data word width in bits; must be at least 2.
- FRAME_LEN, 4: words per frame; must be at least 1.
- ODD, 0: parity sense. 0 means even parity, where the expected tag is the XOR of the data. 1 means odd parity, where the expected tag is the inverted XOR.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- abort  in  1  synchronous frame abort.
- in_valid  in  1  input word valid.
- in_ready  out  1  input word accepted when in_valid && in_ready.
- in_data  in  WIDTH  data word.
- in_par  in  1  transmitted parity tag for in_data.
- out_valid  out  1  frame result valid.
- out_ready  in  1  result consumed when out_valid && out_ready.
- out_frame_par  out  1  XOR of all recomputed word parities in the frame.
- out_err_cnt  out  CW  number of words in the frame whose tag mismatched. CW = $clog2(FRAME_LEN+1).
- out_err  out  1  high when out_err_cnt is nonzero.

## Operation
- The recomputed word parity is wp = ^in_data ^ ODD.
- A word is a mismatch when wp != in_par.
- Internal state:
  - word counter wcnt, width CW, range 0..FRAME_LEN-1;
  - running parity acc_par;
  - running mismatch count acc_err, width CW;
  - a one-deep result register holding out_valid, out_frame_par, out_err_cnt and out_err.
- Two states:
  - ACCUM: the result register is empty.
  - HOLD: a result is pending.
- in_ready = !out_valid || out_ready. This is combinational, so a result can be drained and a new word accepted in the same cycle.
- On an accepted word while wcnt < FRAME_LEN-1:
  - wcnt increments;
  - acc_par ^= wp;
  - acc_err increments when the word is a mismatch.
- On an accepted word while wcnt == FRAME_LEN-1 (the last word):
  - the result register loads out_frame_par = acc_par ^ wp and out_err_cnt = acc_err + mismatch, and out_err follows from that count;
  - out_valid is set and the state becomes HOLD;
  - wcnt, acc_par and acc_err return to 0.
- On a drain (out_valid && out_ready) with no simultaneous last word: out_valid clears and the state returns to ACCUM.
- On a simultaneous drain and last word: the new result loads and out_valid stays 1.
- Result fields are stable while out_valid=1 and out_ready=0.
- abort clears wcnt, acc_par and acc_err.
  - An abort does not disturb a pending result.
  - A word presented in the same cycle as abort is consumed and discarded; it is not counted.
- acc_err never exceeds FRAME_LEN, so no saturation logic is needed.
- When FRAME_LEN=1, every accepted word produces a result.

## Timing
- Reset values: out_valid=0, out_frame_par=0, out_err_cnt=0, out_err=0, wcnt=0, acc_par=0, acc_err=0, state ACCUM. in_ready reads 1 during and after reset.
- Latency: out_valid rises on the clock edge that accepts the last word, i.e. it is visible in the following cycle.
- Throughput: one word per cycle, sustained, while out_ready=1.
- Backpressure: while out_valid=1 and out_ready=0, in_ready=0 and no words are accepted.
- Reset asserted mid-frame clears all partial state immediately and asynchronously. A pending result is lost.
- The wcnt wrap from FRAME_LEN-1 to 0 coincides with the result load.

## Structure
- Package parity_pkg:
  - constant function for CW (clog2);
  - typedef for the result record (frame_par, err_cnt, err).
- Sub-module parity_word: a combinational WIDTH-bit XOR reduction with ODD inversion, producing wp.
  - It is built from a primitive xor gate reduction, matching the upstream stage.
  - It is instantiated once.
- The top level holds the counter, the accumulators, the result register and the handshake logic.

## Test plan
All scenarios use defaults WIDTH=4, FRAME_LEN=4, ODD=0.
- Reset: hold rst_n=0 for 2 cycles, then release -> out_valid=0, out_err_cnt=0, in_ready=1.
- Clean frame, out_ready=1:
  - stimulus: words 0001/p1, 0011/p0, 0111/p1, 1111/p0 on consecutive cycles;
  - response: one cycle after the 4th word, out_valid=1 for exactly 1 cycle, out_frame_par=0, out_err_cnt=0, out_err=0.
- One bad tag: same frame but the 2nd word tagged p1 -> out_err_cnt=1, out_err=1, out_frame_par=0.
- Backpressure:
  - out_ready=0 after a result -> in_ready=0, the next word stalls, and the result fields are unchanged for 5 cycles;
  - then raise out_ready with in_valid=1 -> the result drains and the word is accepted as word 1 of the next frame; the next result appears after 3 more words.
- Abort:
  - accept 2 words, then abort=1 with in_valid=1;
  - then send 4 clean words -> a single result covering only the final 4 words, with out_err_cnt=0.
- Reset mid-frame:
  - accept 3 words, each with a mismatched tag, then pulse rst_n=0;
  - then send the clean frame -> out_err_cnt=0 and no spurious earlier out_valid.
